id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_id_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - instruction decode stage with load-use interlock and user-mode trap
//
// Decodes one 16-bit instruction per cycle into a registered execute-stage record.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_instr/if_pc  fetch-side offer; if_ready accepts it
//   mode                     processor mode (2'b01 = user)
//   flush                    kill pipeline contents
//   ex_ready                 execute stage consumes the ex_* record
//   ex_valid, ex_opcode, ex_p0_addr, ex_p1_addr, ex_dst_addr, ex_we, ex_imm, ex_pc
//                            registered decode result
//   trap, trap_pc, trap_ack  bad-instruction trap handshake
module id_pipe #(
    parameter int DATA_W       = 16,
    parameter int USER_MAX_REG = 12,
    parameter int LD_USE_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              if_ready,
    input  logic [1:0]        mode,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [3:0]        ex_p0_addr,
    output logic [3:0]        ex_p1_addr,
    output logic [3:0]        ex_dst_addr,
    output logic              ex_we,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              trap,
    output logic [DATA_W-1:0] trap_pc,
    input  logic              trap_ack
);

    typedef enum logic {ST_RUN, ST_TRAP} state_t;

    localparam logic [1:0] LD_INIT = 2'(LD_USE_STALL);
    localparam logic [3:0] OP_LOAD = 4'h3;
    localparam logic [3:0] OP_RECV = 4'hE;

    state_t            state_q;
    logic              ex_valid_q;
    logic [3:0]        ex_opcode_q, ex_p0_q, ex_p1_q, ex_dst_q;
    logic              ex_we_q;
    logic [DATA_W-1:0] ex_imm_q, ex_pc_q;
    logic              trap_q;
    logic [DATA_W-1:0] trap_pc_q;
    logic [1:0]        ld_cnt_q, ld_cnt_d;
    logic [3:0]        ld_dst_q;

    // Combinational decode of the offered instruction
    logic [3:0]        op, p0, p1, dst;
    logic              rd0, rd1, we;
    logic [DATA_W-1:0] imm;
    logic              bad, hazard, accept, good_accept, bad_accept;

    always_comb begin
        op  = if_instr[15:12];
        p0  = 4'd0;
        p1  = 4'd0;
        rd0 = 1'b0;
        rd1 = 1'b0;
        dst = 4'd0;
        we  = 1'b0;
        imm = '0;
        case (op)
            4'h0, 4'h1, 4'h2: begin
                p0 = if_instr[7:4];  rd0 = 1'b1;
                p1 = if_instr[3:0];  rd1 = 1'b1;
                dst = if_instr[11:8]; we = |if_instr[11:8];
            end
            4'h3: begin
                p0 = if_instr[7:4];  rd0 = 1'b1;
                dst = if_instr[11:8]; we = |if_instr[11:8];
            end
            4'h4: begin
                p0 = if_instr[7:4];  rd0 = 1'b1;
                p1 = if_instr[11:8]; rd1 = 1'b1;
            end
            4'h5, 4'h6: begin
                p0 = if_instr[11:8]; rd0 = 1'b1;
                dst = if_instr[11:8]; we = |if_instr[11:8];
                imm = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
            end
            4'h7: begin
                p0 = if_instr[11:8]; rd0 = 1'b1;
                dst = if_instr[11:8]; we = |if_instr[11:8];
                imm = {{(DATA_W-4){1'b0}}, if_instr[3:0]};
            end
            4'h8: imm = {{(DATA_W-9){if_instr[8]}}, if_instr[8:0]};
            4'h9: begin
                dst = 4'd12; we = 1'b1;
                imm = {{(DATA_W-12){if_instr[11]}}, if_instr[11:0]};
            end
            4'hA: begin
                p0 = if_instr[11:8]; rd0 = 1'b1;
            end
            4'hB: begin
                if (if_instr[7:6] == 2'b01 && !if_instr[4]) begin
                    p0 = if_instr[11:8]; rd0 = 1'b1;
                end
                dst = if_instr[11:8];
                we  = (if_instr[7:6] == 2'b10);
            end
            4'hC: begin
                if (!if_instr[1]) begin
                    p1 = if_instr[11:8]; rd1 = 1'b1;
                end
                imm = {{(DATA_W-8){1'b0}}, if_instr[11:4]};
            end
            4'hE: begin
                dst = if_instr[11:8]; we = |if_instr[11:8];
            end
            4'hF: begin
                p0 = if_instr[7:4];  rd0 = 1'b1;
                dst = if_instr[11:8]; we = |if_instr[11:8];
                imm = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
            end
            default: ;
        endcase
    end

    // User mode may only touch registers 0..USER_MAX_REG; RECV needs bit 7 set
    assign bad = (mode == 2'b01) &&
                 ((rd0 && (32'(p0) > USER_MAX_REG)) ||
                  (rd1 && (32'(p1) > USER_MAX_REG)) ||
                  (we  && (32'(dst) > USER_MAX_REG)) ||
                  (op == OP_RECV && !if_instr[7]));

    // ld_cnt stays 0 when LD_USE_STALL is 0, which disables the interlock
    assign hazard = (ld_cnt_q != 2'd0) &&
                    ((rd0 && p0 == ld_dst_q) || (rd1 && p1 == ld_dst_q));

    assign if_ready = !rst && !flush && (state_q == ST_RUN) && !hazard &&
                      (!ex_valid_q || ex_ready);
    assign accept      = if_valid && if_ready;
    assign good_accept = accept && !bad;
    assign bad_accept  = accept && bad;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (good_accept && op == OP_LOAD && we)
            ld_cnt_d = LD_INIT;
        else if (ld_cnt_q != 2'd0)
            ld_cnt_d = ld_cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= 4'd0;
            ex_p0_q     <= 4'd0;
            ex_p1_q     <= 4'd0;
            ex_dst_q    <= 4'd0;
            ex_we_q     <= 1'b0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
            trap_q      <= 1'b0;
            trap_pc_q   <= '0;
            ld_cnt_q    <= 2'd0;
            ld_dst_q    <= 4'd0;
        end else if (flush) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            trap_q     <= 1'b0;
            ld_cnt_q   <= 2'd0;
        end else begin
            if (good_accept) begin
                ex_valid_q  <= 1'b1;
                ex_opcode_q <= op;
                ex_p0_q     <= p0;
                ex_p1_q     <= p1;
                ex_dst_q    <= dst;
                ex_we_q     <= we;
                ex_imm_q    <= imm;
                ex_pc_q     <= if_pc;
            end else if (ex_ready) begin
                ex_valid_q <= 1'b0;
            end

            ld_cnt_q <= ld_cnt_d;
            if (good_accept && op == OP_LOAD && we)
                ld_dst_q <= dst;

            case (state_q)
                ST_RUN: begin
                    if (bad_accept) begin
                        state_q   <= ST_TRAP;
                        trap_q    <= 1'b1;
                        trap_pc_q <= if_pc;
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        state_q <= ST_RUN;
                        trap_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_p0_addr  = ex_p0_q;
    assign ex_p1_addr  = ex_p1_q;
    assign ex_dst_addr = ex_dst_q;
    assign ex_we       = ex_we_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc       = ex_pc_q;
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - directed self-checking bench for id_pipe
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ex_ready, trap_ack;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [1:0]  mode;

    logic        if_ready, ex_valid, ex_we, trap;
    logic [3:0]  ex_opcode, ex_p0, ex_p1, ex_dst;
    logic [15:0] ex_imm, ex_pc, trap_pc;

    logic        if_ready2, ex_valid2, ex_we2, trap2;
    logic [3:0]  ex_opcode2, ex_p02, ex_p12, ex_dst2;
    logic [15:0] ex_imm2, ex_pc2, trap_pc2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_pipe #(.DATA_W(16), .USER_MAX_REG(12), .LD_USE_STALL(1)) u_dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .mode(mode), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_p0_addr(ex_p0), .ex_p1_addr(ex_p1),
        .ex_dst_addr(ex_dst), .ex_we(ex_we), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .trap(trap), .trap_pc(trap_pc), .trap_ack(trap_ack)
    );

    id_pipe #(.DATA_W(16), .USER_MAX_REG(12), .LD_USE_STALL(2)) u_dut2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready2), .mode(mode), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid2), .ex_opcode(ex_opcode2), .ex_p0_addr(ex_p02), .ex_p1_addr(ex_p12),
        .ex_dst_addr(ex_dst2), .ex_we(ex_we2), .ex_imm(ex_imm2), .ex_pc(ex_pc2),
        .trap(trap2), .trap_pc(trap_pc2), .trap_ack(trap_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a settle delay
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b1; if_instr = 16'h0312; if_pc = 16'h0;
        mode = 2'b00; flush = 1'b0; ex_ready = 1'b1; trap_ack = 1'b0;
        step(); step(); #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_pc", trap_pc, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_dst", ex_dst, 0);
        chk("rst_if_ready", if_ready, 0);

        // ADD decode
        rst = 1'b0; if_pc = 16'h0010; #1;
        chk("add_if_ready", if_ready, 1);
        step();
        chk("add_valid", ex_valid, 1);
        chk("add_opcode", ex_opcode, 0);
        chk("add_p0", ex_p0, 1);
        chk("add_p1", ex_p1, 2);
        chk("add_dst", ex_dst, 3);
        chk("add_we", ex_we, 1);
        chk("add_imm", ex_imm, 0);
        chk("add_pc", ex_pc, 16'h0010);

        // Immediate forms
        if_instr = 16'hF21C; if_pc = 16'h0012; step();
        chk("addi_imm", ex_imm, 16'hFFFC);
        chk("addi_dst", ex_dst, 2);
        chk("addi_p1", ex_p1, 0);
        if_instr = 16'h8F80; step();
        chk("br_imm", ex_imm, 16'hFF80);
        chk("br_we", ex_we, 0);
        if_instr = 16'h9800; step();
        chk("jl_imm", ex_imm, 16'hF800);
        chk("jl_dst", ex_dst, 12);
        chk("jl_we", ex_we, 1);
        if_instr = 16'hCAB4; step();
        chk("send_imm", ex_imm, 16'h00AB);
        chk("send_p1", ex_p1, 4'hA);
        chk("send_p0", ex_p0, 0);

        // Load-use interlock: dut stalls one cycle, dut2 two cycles
        if_instr = 16'h3540; if_pc = 16'h0020; step();
        chk("ld_opcode", ex_opcode, 3);
        chk("ld_dst", ex_dst, 5);
        if_instr = 16'h0651; if_pc = 16'h0030; #1;
        chk("lu1_stall_c1", if_ready, 0);
        chk("lu2_stall_c1", if_ready2, 0);
        step();
        chk("lu1_bubble", ex_valid, 0);
        chk("lu1_ready_c2", if_ready, 1);
        chk("lu2_stall_c2", if_ready2, 0);
        step();
        chk("lu1_acc_valid", ex_valid, 1);
        chk("lu1_acc_p0", ex_p0, 5);
        chk("lu2_ready_c3", if_ready2, 1);
        step();
        chk("lu2_acc_valid", ex_valid2, 1);
        chk("lu2_acc_p0", ex_p02, 5);

        // Execute back-pressure holds the record
        ex_ready = 1'b0; if_instr = 16'h2456; if_pc = 16'h0032; #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_if_ready", if_ready, 0);
            step();
            chk("stall_valid", ex_valid, 1);
            chk("stall_p0", ex_p0, 5);
            chk("stall_pc", ex_pc, 16'h0030);
        end
        flush = 1'b1; step(); flush = 1'b0; #1;
        chk("flush_valid", ex_valid, 0);
        chk("flush_if_ready", if_ready, 1);

        // Flush clears the load scoreboard
        ex_ready = 1'b1; if_instr = 16'h3540; if_pc = 16'h0040; step();
        if_instr = 16'h0651; if_pc = 16'h0042; flush = 1'b1; #1;
        chk("flush_blocks_ready", if_ready2, 0);
        step(); flush = 1'b0; #1;
        chk("flush_ld_cnt", if_ready2, 1);
        chk("flush_valid2", ex_valid2, 0);
        step();

        // User-mode trap on out-of-range destination
        mode = 2'b01; if_instr = 16'h0D12; if_pc = 16'h0040; #1;
        chk("trap_offer_ready", if_ready, 1);
        step();
        chk("trap_set", trap, 1);
        chk("trap_pc", trap_pc, 16'h0040);
        chk("trap_no_valid", ex_valid, 0);
        chk("trap_if_ready", if_ready, 0);
        if_pc = 16'h0050; step();
        chk("trap_hold", trap, 1);
        chk("trap_pc_hold", trap_pc, 16'h0040);
        chk("trap_hold_ready", if_ready, 0);
        if_valid = 1'b0; trap_ack = 1'b1; step(); trap_ack = 1'b0; #1;
        chk("trap_ack_clr", trap, 0);
        chk("trap_ack_ready", if_ready, 1);

        // RECV legality in user mode, then reset abandons a trap
        if_valid = 1'b1; if_instr = 16'hE380; if_pc = 16'h0060; step();
        chk("recv_ok_valid", ex_valid, 1);
        chk("recv_ok_trap", trap, 0);
        chk("recv_ok_dst", ex_dst, 3);
        if_instr = 16'hE300; if_pc = 16'h0062; step();
        chk("recv_bad_trap", trap, 1);
        chk("recv_bad_pc", trap_pc, 16'h0062);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_trap_clr", trap, 0);
        mode = 2'b00; if_instr = 16'h0312; if_pc = 16'h0070; #1;
        chk("post_rst_ready", if_ready, 1);
        step();
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_pc", ex_pc, 16'h0070);

        // Sustained throughput: 8 independent instructions back to back
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ins;
            ins = {4'h2, 4'(i + 1), 8'h12};
            if_instr = ins; if_pc = 16'(16'h0100 + 2 * i); #1;
            chk("b2b_ready", if_ready, 1);
            step();
            chk("b2b_valid", ex_valid, 1);
            chk("b2b_pc", ex_pc, 32'(16'h0100 + 2 * i));
            chk("b2b_dst", ex_dst, 32'(i + 1));
        end
        if_valid = 1'b0; step();
        chk("drain_valid", ex_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
